// File: rtl/regfile_dump_reader.sv
// Debug reader that walks register-file indices FIRST_REG..LAST_REG and streams each
// register as a 5-byte frame {index, data[31:24], data[23:16], data[15:8], data[7:0]}.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rf_rd_en,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
    localparam logic [2:0] LAST_BYTE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_NEXT    = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= FIRST_IDX;
            cnt_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        busy      = 1'b0;
        done      = 1'b0;
        rf_rd_en  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy     = 1'b1;
                rf_rd_en = 1'b1;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy    = 1'b1;
                shift_d = rf_rd_data;
                byte_d  = {3'b000, idx_q};
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // The shift register always holds the next data byte in its top lane,
                // so the following byte is ready on the cycle after each acceptance.
                if (out_ready) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        byte_d  = shift_q[31:24];
                        shift_d = {shift_q[23:0], 8'h00};
                    end
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                idx_d   = FIRST_IDX;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rf_rd_addr = idx_q;
    assign out_byte   = byte_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: a reference model queues expected frames per dump, monitors pop
// and compare on every accepted byte.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, busy_a, done_a, rf_rd_en_a, out_valid_a, out_ready_a = 1'b1;
    logic [4:0]  rf_rd_addr_a;
    logic [31:0] rd_a = '0;
    logic [7:0]  out_byte_a;

    logic        start_b = 1'b0, busy_b, done_b, rf_rd_en_b, out_valid_b, out_ready_b = 1'b1;
    logic [4:0]  rf_rd_addr_b;
    logic [31:0] rd_b = '0;
    logic [7:0]  out_byte_b;

    logic [31:0] regs [32];
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];

    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0, start_cyc = 0, done_cyc_a = 0;
    int unsigned bytes_a = 0, bytes_b = 0, rden_a = 0, rden_b = 0;
    int unsigned done_cnt_a = 0, done_cnt_b = 0;
    int unsigned mode_a = 0, k_b = 0;
    logic        pv_a = 0, pr_a = 0, pv_b = 0, pr_b = 0;
    logic [7:0]  pb_a = '0, pb_b = '0;

    regfile_dump_reader u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rf_rd_en(rf_rd_en_a), .rf_rd_addr(rf_rd_addr_a), .rf_rd_data(rd_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_byte(out_byte_a)
    );

    regfile_dump_reader #(.FIRST_REG(29), .LAST_REG(29)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rf_rd_en(rf_rd_en_b), .rf_rd_addr(rf_rd_addr_b), .rf_rd_data(rd_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_byte(out_byte_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Register file: data only meaningful the cycle after a strobe.
    always @(posedge clk) begin
        rd_a <= rf_rd_en_a ? regs[rf_rd_addr_a] : 32'hDEAD_BEEF;
        rd_b <= rf_rd_en_b ? regs[rf_rd_addr_b] : 32'hDEAD_BEEF;
    end

    // Downstream ready: A by mode (0 high, 1 random, 2 low), B toggles 1,0,0,...
    always @(posedge clk) begin
        #1;
        out_ready_b = (k_b % 3 == 0);
        k_b++;
        case (mode_a)
            0: out_ready_a = 1'b1;
            1: out_ready_a = 1'($urandom_range(0, 1));
            default: out_ready_a = 1'b0;
        endcase
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_dump(bit to_b, int unsigned first, int unsigned last);
        for (int unsigned r = first; r <= last; r++) begin
            if (to_b) qb.push_back(8'(r)); else qa.push_back(8'(r));
            for (int k = 3; k >= 0; k--) begin
                if (to_b) qb.push_back(8'((regs[r] >> (8 * k)) & 32'hFF));
                else      qa.push_back(8'((regs[r] >> (8 * k)) & 32'hFF));
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pv_a = 0;
        end else begin
            if (out_valid_a) begin
                if (pv_a && !pr_a) check("stall_hold_a", 32'(out_byte_a), 32'(pb_a));
                if (out_ready_a) begin
                    if (qa.size() == 0) check("extra_byte_a", 32'(out_byte_a), 32'hFFFF_FFFF);
                    else check("byte_a", 32'(out_byte_a), 32'(qa.pop_front()));
                    bytes_a++;
                end
            end
            if (rf_rd_en_a) rden_a++;
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            pv_a = out_valid_a; pr_a = out_ready_a; pb_a = out_byte_a;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv_b = 0;
        end else begin
            if (out_valid_b) begin
                if (pv_b && !pr_b) check("stall_hold_b", 32'(out_byte_b), 32'(pb_b));
                if (out_ready_b) begin
                    if (qb.size() == 0) check("extra_byte_b", 32'(out_byte_b), 32'hFFFF_FFFF);
                    else check("byte_b", 32'(out_byte_b), 32'(qb.pop_front()));
                    bytes_b++;
                end
            end
            if (rf_rd_en_b) begin
                rden_b++;
                check("rd_addr_b", 32'(rf_rd_addr_b), 32'd29);
            end
            if (done_b) done_cnt_b++;
            pv_b = out_valid_b; pr_b = out_ready_b; pb_b = out_byte_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump_a();
        push_dump(1'b0, 0, 31);
        bytes_a   = 0;
        start_cyc = cyc;
        start_a   = 1'b1;
        tick();
        start_a   = 1'b0;
    endtask

    task automatic wait_done_a(input int unsigned prev, input string tag);
        int unsigned n = 0;
        while (done_cnt_a == prev && n < 6000) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(done_cnt_a != prev), 32'd1);
        #1;
    endtask

    task automatic wait_cond_a(input int unsigned which, input string tag);
        int unsigned n = 0;
        bit hit = 0;
        while (!hit && n < 6000) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = out_valid_a;
                1: hit = out_valid_a && rf_rd_addr_a == 5'd5;
                default: hit = done_a;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        int unsigned d0, r0;
        bit ok;

        foreach (regs[i]) regs[i] = $urandom;
        regs[0]  = 32'h0;
        regs[28] = 32'h0000_189C;
        regs[29] = 32'h0000_C7FF;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rden", 32'(rf_rd_en_a), 32'd0);
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_addr_a", 32'(rf_rd_addr_a), 32'd0);
        check("rst_byte", 32'(out_byte_a), 32'd0);
        check("rst_addr_b", 32'(rf_rd_addr_b), 32'd29);
        tick();

        // Full default dump with ready high
        start_dump_a();
        wait_done_a(0, "done_timeout_1");
        check("bytes_1", bytes_a, 32'd160);
        check("done_cnt_1", done_cnt_a, 32'd1);
        check("latency_1", done_cyc_a - start_cyc, 32'd257);
        check("rden_1", rden_a, 32'd32);
        check("q_empty_1", 32'(qa.size()), 32'd0);

        // Single-register instance with toggling ready
        push_dump(1'b1, 29, 29);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int unsigned n = 0; n < 200 && done_cnt_b == 0; n++) tick();
        check("done_b", done_cnt_b, 32'd1);
        check("bytes_b", bytes_b, 32'd5);
        check("rden_b", rden_b, 32'd1);
        check("q_empty_b", 32'(qb.size()), 32'd0);

        // Start re-pulsed while busy, then start during FIN
        regs[0] = $urandom | 32'h1;
        mode_a = 1;
        d0 = done_cnt_a;
        r0 = rden_a;
        start_dump_a();
        wait_cond_a(1, "reach_reg5");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_cond_a(2, "done_timeout_3");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("fin_start_ignored", 32'(busy_a), 32'd0);
        check("done_cnt_3", done_cnt_a - d0, 32'd1);
        check("bytes_3", bytes_a, 32'd160);
        check("rden_3", rden_a - r0, 32'd32);
        check("q_empty_3", 32'(qa.size()), 32'd0);
        tick();

        // Reset mid-frame after two bytes of register 3
        mode_a = 0;
        tick();
        d0 = done_cnt_a;
        start_dump_a();
        for (int unsigned n = 0; n < 400 && bytes_a < 17; n++) tick();
        check("bytes_before_rst", bytes_a, 32'd17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qa.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_addr", 32'(rf_rd_addr_a), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        tick();
        check("mid_rst_no_done", done_cnt_a - d0, 32'd0);
        start_dump_a();
        wait_done_a(done_cnt_a, "done_timeout_4");
        check("bytes_4", bytes_a, 32'd160);
        check("q_empty_4", 32'(qa.size()), 32'd0);

        // First byte stalled for 100 cycles
        mode_a = 2;
        tick();
        r0 = rden_a;
        d0 = done_cnt_a;
        start_dump_a();
        wait_cond_a(0, "first_valid_5");
        ok = 1;
        for (int unsigned i = 0; i < 100; i++) begin
            if (!(out_valid_a && out_byte_a == 8'h00 && !rf_rd_en_a)) ok = 0;
            @(negedge clk);
        end
        check("stall100", 32'(ok), 32'd1);
        check("stall_rden", rden_a - r0, 32'd1);
        mode_a = 0;
        wait_done_a(d0, "done_timeout_5");
        check("bytes_5", bytes_a, 32'd160);

        // Back-to-back dumps with random ready
        mode_a = 1;
        r0 = rden_a;
        d0 = done_cnt_a;
        start_dump_a();
        wait_done_a(d0, "done_timeout_6a");
        start_dump_a();
        wait_done_a(d0 + 1, "done_timeout_6b");
        check("bytes_6", bytes_a, 32'd160);
        check("rden_6", rden_a - r0, 32'd64);
        check("done_cnt_6", done_cnt_a - d0, 32'd2);
        check("q_empty_6", 32'(qa.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug-side reader for the CPU register file.
- On a start pulse it walks register indices FIRST_REG..LAST_REG, issues one read strobe per index and captures the 32-bit read data.
- Each register is emitted as a 5-byte frame on a valid/ready byte stream, for the board's UART TX.
- It sits beside the core on the Basys3 top level and owns the register file's read port 1 while busy.

Parameters:
FIRST_REG, 0, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG..31)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a dump
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last byte is accepted
rf_rd_en  output  1  read strobe to register file, one cycle per index
rf_rd_addr  output  5  register index being read
rf_rd_data  input  32  register file read data, valid the cycle after rf_rd_en
out_valid  output  1  byte available on out_byte
out_ready  input  1  downstream accepts byte when out_valid && out_ready
out_byte  output  8  stream byte

Behaviour:
- Reset (sync, active-high) forces:
  - state IDLE; busy, done, rf_rd_en, out_valid = 0
  - rf_rd_addr = FIRST_REG; out_byte = 0
  - index counter = FIRST_REG; byte counter = 0
- Reset mid-dump aborts immediately. No partial frame completes, and there is no done pulse.
- States: IDLE, ISSUE, CAPTURE, SEND, NEXT, FIN.
- IDLE:
  - start=1 -> ISSUE; busy=1 from the next cycle.
  - start while not IDLE is ignored; no queuing.
- ISSUE (1 cycle): rf_rd_en=1, rf_rd_addr=index -> CAPTURE.
- CAPTURE (1 cycle): rf_rd_en=0, rf_rd_addr held. At the clock edge, latch rf_rd_data into a 32-bit shift register. Next state SEND with byte counter=0.
- SEND: out_valid=1; frame byte order by byte counter:
  - 0: {3'b000, index}
  - 1: data[31:24]
  - 2: data[23:16]
  - 3: data[15:8]
  - 4: data[7:0]
- SEND handshake:
  - out_byte is registered and stable while out_valid && !out_ready.
  - out_valid never drops before acceptance.
  - On acceptance with byte counter<4: increment and present the next byte the following cycle. out_valid stays high, so there is no bubble between bytes.
  - On acceptance with byte counter=4: out_valid=0 next cycle -> NEXT.
- NEXT (1 cycle):
  - index==LAST_REG -> FIN.
  - else index+1 -> ISSUE.
  - Index never wraps past 31.
- FIN (1 cycle): done=1, busy=0 from the next cycle -> IDLE.
- Latency:
  - start to first rf_rd_en: 1 cycle.
  - start to first out_valid: 3 cycles.
  - With out_ready tied high, each register takes 8 cycles (ISSUE, CAPTURE, 5 SEND, NEXT).
- Total output is 5*(LAST_REG-FIRST_REG+1) bytes.
- rf_rd_en is never asserted outside ISSUE. The block never writes the register file.
- Register index 0 is dumped like any other. It reads whatever the file returns; no forcing to zero.
- start on the same cycle as FIN is ignored. A new start is accepted from IDLE the cycle after.

Test Plan:
1. Reset, then start with defaults, file model regs[28]=0x0000189C, regs[29]=0x0000C7FF, out_ready=1:
   - 160 bytes total.
   - Frame 28 = 1C 00 00 18 9C.
   - Frame 29 = 1D 00 00 C7 FF.
   - Frame 0 = 00 00 00 00 00.
   - done pulses once; total 257 cycles start->done.
2. FIRST_REG=LAST_REG=29 with out_ready toggling 1,0,0,1,...:
   - Exactly 1D 00 00 C7 FF.
   - out_byte stable across every stalled cycle.
   - rf_rd_en high exactly 1 cycle with rf_rd_addr=29.
3. start re-pulsed while busy (during SEND of register 5): no restart, byte sequence unchanged, single done.
4. rst asserted mid-frame (after 2 bytes of register 3): next cycle out_valid=0, busy=0, rf_rd_addr=FIRST_REG, no done. A new start restarts from FIRST_REG.
5. out_ready held 0 for 100 cycles at first byte: out_valid=1 and out_byte=0x00 throughout, no further rf_rd_en, then normal completion.
6. Back-to-back dumps (start one cycle after done): second stream identical to first, and rf_rd_en count = 2*(LAST_REG-FIRST_REG+1).
